display_scanner: RTL



---
 rtl/display_pkg.sv | 28 ++
 rtl/seg7_decoder.sv | 32 +++
 rtl/display_scanner.sv | 139 +++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared 7-segment codes (active-high, a = bit 0) and scanner state type
package display_pkg;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_BLANK,
    ST_SHOW
  } scan_state_e;

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational hex nibble to active-high 7-segment code
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - multiplexed 7-segment scanner stepped by a synchronized clk_dpl
module display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int BLANK_CYCLES   = 64,
  parameter bit BOTH_EDGES     = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_dpl,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  logic sync1_q, sync2_q, sync3_q, step_q, edge_d;
  scan_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic advance, new_frame;
  logic [4*NUM_DIGITS-1:0] snap_digits_q, nib_shift;
  logic [NUM_DIGITS-1:0] snap_dp_q, an_hi;
  logic snap_lz_q, lz_hide, dp_hi;
  logic [6:0] dec_seg, seg_hi;

  // step is registered so the FSM never sees the raw edge-detect term
  always_comb edge_d = BOTH_EDGES ? (sync2_q ^ sync3_q) : (sync2_q & ~sync3_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      sync1_q <= clk_dpl;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      step_q  <= edge_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_WAIT;
      idx_q         <= LAST_IDX;
      cnt_q         <= '0;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      snap_lz_q     <= 1'b0;
      frame_start   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      frame_start <= new_frame;
      if (new_frame) begin
        snap_digits_q <= digits;
        snap_dp_q     <= dp_en;
        snap_lz_q     <= lz_blank;
      end
    end
  end

  // a step landing in BLANK is deliberately ignored
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    advance = 1'b0;
    case (state_q)
      ST_WAIT, ST_SHOW: begin
        if (step_q) begin
          if (BLANK_CYCLES == 0) begin
            state_d = ST_SHOW;
            advance = 1'b1;
          end else begin
            state_d = ST_BLANK;
            cnt_d   = BLANK_LOAD;
          end
        end
      end
      ST_BLANK: begin
        if (cnt_q == '0) begin
          state_d = ST_SHOW;
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_WAIT;
    endcase
    if (advance) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    new_frame = advance && (idx_d == '0);
  end

  seg7_decoder u_dec (
    .nibble_i (nib_shift[3:0]),
    .seg_o    (dec_seg)
  );

  always_comb begin
    nib_shift = snap_digits_q >> {idx_q, 2'b00};
    lz_hide   = snap_lz_q && (idx_q != '0) && (nib_shift == '0);
    an_hi     = '0;
    seg_hi    = SEG_OFF;
    dp_hi     = 1'b0;
    if (state_q == ST_SHOW) begin
      an_hi[idx_q] = 1'b1;
      dp_hi        = snap_dp_q[idx_q];
      if (!lz_hide) seg_hi = dec_seg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= {7{SEG_ACTIVE_LOW}};
      dp  <= SEG_ACTIVE_LOW;
      an  <= {NUM_DIGITS{AN_ACTIVE_LOW}};
    end else begin
      seg <= seg_hi ^ {7{SEG_ACTIVE_LOW}};
      dp  <= dp_hi ^ SEG_ACTIVE_LOW;
      an  <= an_hi ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
    end
  end

endmodule
